// File: rtl/wbxbc_syscon_pkg.sv
// -----------------------------------------------------------------------------
// wbxbc_syscon_pkg
// Shared definitions for the WbXbc SYSCON reset / clock-enable sequencer:
//   - state_t      : sequencer FSM states (POR, RELEASE, RUN)
//   - ADR_*        : Wishbone register addresses
//   - cnt_w()      : counter width helper for the delay/hold counters
// -----------------------------------------------------------------------------
package wbxbc_syscon_pkg;

    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [1:0] ADR_RST  = 2'd0;
    localparam logic [1:0] ADR_CEN  = 2'd1;
    localparam logic [1:0] ADR_STAT = 2'd2;

    // Width able to hold the value v itself (the counters compare against
    // their terminal value, so clog2(v) alone would be one bit short for
    // powers of two). Never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/wbxbc_syscon_dom.sv
// -----------------------------------------------------------------------------
// wbxbc_syscon_dom
// One managed clock domain: its reset flop and the minimum-hold counter.
//   clk_i       in   system clock
//   sync_rst_i  in   synchronous active-high reset (forces the domain into reset)
//   i_rel       in   release strobe for this domain's slot (POR/RELEASE only)
//   i_rst_bit   in   RST register bit: 1 = hold domain in reset
//   i_cen_bit   in   CEN register bit: clock enable request
//   i_run       in   sequencer is in RUN; enables soft reset handling
//   o_dom_rst   out  registered domain reset, active-high
//   o_dom_sync  out  clock enable, forced on while the domain is in reset
// -----------------------------------------------------------------------------
module wbxbc_syscon_dom
    import wbxbc_syscon_pkg::*;
#(
    parameter int MIN_RST = 3
) (
    input  logic clk_i,
    input  logic sync_rst_i,
    input  logic i_rel,
    input  logic i_rst_bit,
    input  logic i_cen_bit,
    input  logic i_run,
    output logic o_dom_rst,
    output logic o_dom_sync
);

    localparam int HOLD_W = cnt_w(MIN_RST);

    logic              r_dom_rst;
    logic [HOLD_W-1:0] r_hold;

    // r_hold counts the reset cycles still owed after the current one, so
    // it is loaded with MIN_RST-1 on entry: the flop is then high for
    // exactly MIN_RST cycles when RST is cleared immediately.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_dom_rst <= 1'b1;
            r_hold    <= '0;
        end else if (!i_run) begin
            // Power-on sequence: only the release slot may clear the reset,
            // and a domain held by RST simply lets its slot pass.
            if (i_rel && !i_rst_bit) begin
                r_dom_rst <= 1'b0;
            end
        end else if (!r_dom_rst) begin
            if (i_rst_bit) begin
                r_dom_rst <= 1'b1;
                r_hold    <= HOLD_W'(MIN_RST - 1);
            end
        end else begin
            // Re-asserting RST while already in reset never reloads r_hold.
            if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end else if (!i_rst_bit) begin
                r_dom_rst <= 1'b0;
            end
        end
    end

    assign o_dom_rst  = r_dom_rst;
    // Both terms are flops, so the enable cannot glitch.
    assign o_dom_sync = i_cen_bit | r_dom_rst;

endmodule

// File: rtl/wbxbc_syscon_ctrl.sv
// -----------------------------------------------------------------------------
// wbxbc_syscon_ctrl
// Reset and clock-enable sequencer for the WbXbc SYSCON resource. After reset
// it waits POR_DLY cycles, releases the N_DOM domain resets one per
// STAGE_DLY cycles in ascending order, then lets software hold domains in
// soft reset (RST) or gate their clock enables (CEN) over Wishbone.
//   clk_i       in   system clock
//   sync_rst_i  in   synchronous active-high reset
//   cyc_i/stb_i in   Wishbone cycle / strobe (pipelined, never stalls)
//   we_i        in   write enable
//   adr_i       in   0=RST, 1=CEN, 2=STATUS (dom_rst_o), 3=reads 0
//   dat_i       in   write data
//   ack_o       out  one-cycle ack after each accepted request
//   stall_o     out  constant 0
//   dat_o       out  read data, valid with ack_o
//   dom_rst_o   out  per-domain reset, active-high
//   dom_sync_o  out  per-domain clock enable
//   por_done_o  out  power-on release sequence finished
// -----------------------------------------------------------------------------
module wbxbc_syscon_ctrl
    import wbxbc_syscon_pkg::*;
#(
    parameter int N_DOM     = 4,
    parameter int POR_DLY   = 4,
    parameter int STAGE_DLY = 2,
    parameter int MIN_RST   = 3
) (
    input  logic             clk_i,
    input  logic             sync_rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [1:0]       adr_i,
    input  logic [N_DOM-1:0] dat_i,
    output logic             ack_o,
    output logic             stall_o,
    output logic [N_DOM-1:0] dat_o,
    output logic [N_DOM-1:0] dom_rst_o,
    output logic [N_DOM-1:0] dom_sync_o,
    output logic             por_done_o
);

    localparam int POR_W = cnt_w(POR_DLY);
    localparam int STG_W = cnt_w(STAGE_DLY);
    localparam int IDX_W = cnt_w(N_DOM);

    // ------------------------------------------------------------------
    // Release sequencer
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [POR_W-1:0] r_por_cnt;
    logic [STG_W-1:0] r_stg_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_por_done;

    logic             w_por_hit;
    logic             w_stg_hit;
    logic             w_last;
    logic [N_DOM-1:0] w_rel;

    // r_por_cnt equals the edge number while in POR, so slot 0 lands on
    // edge POR_DLY. r_stg_cnt restarts at 1 after every slot, so the next
    // slot lands exactly STAGE_DLY edges later.
    assign w_por_hit = (r_state == ST_POR) && (r_por_cnt == POR_W'(POR_DLY));
    assign w_stg_hit = (r_state == ST_RELEASE) && (r_stg_cnt == STG_W'(STAGE_DLY));
    assign w_last    = (N_DOM == 1) ? w_por_hit
                                    : (w_stg_hit && (r_idx == IDX_W'(N_DOM - 1)));

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_state    <= ST_POR;
            r_por_cnt  <= '0;
            r_stg_cnt  <= '0;
            r_idx      <= '0;
            r_por_done <= 1'b0;
        end else begin
            unique case (r_state)
                ST_POR: begin
                    if (w_por_hit) begin
                        r_state   <= (N_DOM == 1) ? ST_RUN : ST_RELEASE;
                        r_stg_cnt <= STG_W'(1);
                        r_idx     <= IDX_W'(1);
                    end else begin
                        r_por_cnt <= r_por_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (w_stg_hit) begin
                        r_stg_cnt <= STG_W'(1);
                        r_idx     <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_stg_cnt <= r_stg_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_POR;
                end
            endcase
            if (w_last) begin
                r_por_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone register file
    // ------------------------------------------------------------------
    logic [N_DOM-1:0] r_rst;
    logic [N_DOM-1:0] r_cen;
    logic             r_ack;
    logic [N_DOM-1:0] r_dat;
    logic             w_req;
    logic [N_DOM-1:0] w_dom_rst;
    logic [N_DOM-1:0] w_dom_sync;

    assign w_req = cyc_i & stb_i;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_rst <= '0;
            r_cen <= '1;
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= '0;
            if (w_req) begin
                if (we_i) begin
                    // STATUS and the spare address swallow writes.
                    if (adr_i == ADR_RST) begin
                        r_rst <= dat_i;
                    end else if (adr_i == ADR_CEN) begin
                        r_cen <= dat_i;
                    end
                end else begin
                    unique case (adr_i)
                        ADR_RST:  r_dat <= r_rst;
                        ADR_CEN:  r_dat <= r_cen;
                        ADR_STAT: r_dat <= w_dom_rst;
                        default:  r_dat <= '0;
                    endcase
                end
            end
        end
    end

    // Dropping cyc_i abandons the cycle, so the pending ack is masked.
    assign ack_o   = r_ack & cyc_i;
    assign stall_o = 1'b0;
    assign dat_o   = r_dat;

    // ------------------------------------------------------------------
    // Per-domain reset / enable
    // ------------------------------------------------------------------
    logic w_run;
    assign w_run = (r_state == ST_RUN);

    for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
        if (gi == 0) begin : g_first
            assign w_rel[gi] = w_por_hit;
        end else begin : g_rest
            assign w_rel[gi] = w_stg_hit && (r_idx == IDX_W'(gi));
        end

        wbxbc_syscon_dom #(
            .MIN_RST (MIN_RST)
        ) u_dom (
            .clk_i      (clk_i),
            .sync_rst_i (sync_rst_i),
            .i_rel      (w_rel[gi]),
            .i_rst_bit  (r_rst[gi]),
            .i_cen_bit  (r_cen[gi]),
            .i_run      (w_run),
            .o_dom_rst  (w_dom_rst[gi]),
            .o_dom_sync (w_dom_sync[gi])
        );
    end

    assign dom_rst_o  = w_dom_rst;
    assign dom_sync_o = w_dom_sync;
    assign por_done_o = r_por_done;

endmodule

// File: tb/tb_wbxbc_syscon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wbxbc_syscon_ctrl
// Self-checking bench for wbxbc_syscon_ctrl with default parameters.
// A timestamp-based reference model tracks every edge; a hand-written vector
// table covers power-up, held-domain release and bus corners; short directed
// sequences cover soft reset timing, clock gating, ack squash and reset
// mid-operation; a random phase exercises everything against the model.
// -----------------------------------------------------------------------------
module tb_wbxbc_syscon_ctrl;

    localparam int N    = 4;
    localparam int POR  = 4;
    localparam int STG  = 2;
    localparam int MINR = 3;
    localparam int LAST = POR + (N - 1) * STG;

    logic         clk_i = 1'b0;
    logic         sync_rst_i;
    logic         cyc_i, stb_i, we_i;
    logic [1:0]   adr_i;
    logic [N-1:0] dat_i;
    logic         ack_o, stall_o, por_done_o;
    logic [N-1:0] dat_o, dom_rst_o, dom_sync_o;

    wbxbc_syscon_ctrl #(
        .N_DOM(N), .POR_DLY(POR), .STAGE_DLY(STG), .MIN_RST(MINR)
    ) dut (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .ack_o      (ack_o),
        .stall_o    (stall_o),
        .dat_o      (dat_o),
        .dom_rst_o  (dom_rst_o),
        .dom_sync_o (dom_sync_o),
        .por_done_o (por_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Edge e counts from the first edge with reset low.
    // Release edges come straight from the slot formula; a soft reset may
    // end once MIN_RST edges have passed since the edge it started on.
    // ------------------------------------------------------------------
    int           m_t;
    logic [N-1:0] m_rst, m_cen, m_dom, m_dat;
    logic         m_done, m_ack;
    int           m_start [N];

    task automatic model_edge(input logic srst, input logic c, input logic s,
                              input logic w, input logic [1:0] a, input logic [N-1:0] d);
        logic [N-1:0] nd;
        int e;
        if (srst) begin
            m_t = 0; m_rst = '0; m_cen = '1; m_dom = '1;
            m_done = 1'b0; m_ack = 1'b0; m_dat = '0;
            for (int i = 0; i < N; i++) m_start[i] = -1000;
            return;
        end
        e = m_t;
        m_t++;
        nd = m_dom;
        for (int i = 0; i < N; i++) begin
            if (e <= LAST) begin
                if (e == POR + i * STG && !m_rst[i]) nd[i] = 1'b0;
            end else if (!m_dom[i] && m_rst[i]) begin
                nd[i] = 1'b1;
                m_start[i] = e;
            end else if (m_dom[i] && !m_rst[i] && (e - m_start[i]) >= MINR) begin
                nd[i] = 1'b0;
            end
        end
        if (e == LAST) m_done = 1'b1;
        m_ack = c && s;
        m_dat = '0;
        if (c && s) begin
            if (w) begin
                if (a == 2'd0) m_rst = d;
                else if (a == 2'd1) m_cen = d;
            end else begin
                case (a)
                    2'd0:    m_dat = m_rst;
                    2'd1:    m_dat = m_cen;
                    2'd2:    m_dat = m_dom;
                    default: m_dat = '0;
                endcase
            end
        end
        m_dom = nd;
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(input logic srst, input logic c, input logic s,
                        input logic w, input logic [1:0] a, input logic [N-1:0] d);
        sync_rst_i = srst; cyc_i = c; stb_i = s; we_i = w; adr_i = a; dat_i = d;
        @(posedge clk_i);
        model_edge(srst, c, s, w, a, d);
        #1;
        chk("dom_rst",  8'(dom_rst_o),  8'(m_dom));
        chk("dom_sync", 8'(dom_sync_o), 8'(m_cen | m_dom));
        chk("por_done", 8'(por_done_o), 8'(m_done));
        chk("ack",      8'(ack_o),      8'(m_ack & c));
        chk("dat",      8'(dat_o),      8'(m_dat));
        chk("stall",    8'(stall_o),    8'd0);
        if (c && s && !srst)
            $display("[TB] %s adr=%0d wdat=%h -> ack=%b rdat=%h dom_rst=%h sync=%h done=%b",
                     w ? "WR" : "RD", a, d, ack_o, dat_o, dom_rst_o, dom_sync_o, por_done_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    typedef struct {
        logic       srst, cyc, stb, we;
        logic [1:0] adr;
        logic [3:0] dat;
        logic [3:0] e_rst, e_sync;
        logic       e_done, e_ack;
        logic [3:0] e_dat;
    } vec_t;

    vec_t tbl [21];

    initial begin
        sync_rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = 2'd0; dat_i = '0;

        // Row index 3 is edge 0. RST[2] is written during POR and held
        // through its slot; reads at edges 8..11 are back-to-back.
        //          srst c  s  w  adr dat   rst   sync  dn ak  rdat
        tbl[0]  = '{1, 0, 0, 0, 0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0};
        tbl[1]  = '{1, 0, 0, 0, 0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0};
        tbl[2]  = '{1, 0, 0, 0, 0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0};
        tbl[3]  = '{0, 0, 0, 0, 0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0};
        tbl[4]  = '{0, 0, 0, 0, 0, 4'h0, 4'hF, 4'hF, 0, 0, 4'h0};
        tbl[5]  = '{0, 1, 1, 1, 0, 4'h4, 4'hF, 4'hF, 0, 1, 4'h0};
        tbl[6]  = '{0, 1, 1, 0, 2, 4'h0, 4'hF, 4'hF, 0, 1, 4'hF};
        tbl[7]  = '{0, 0, 0, 0, 0, 4'h0, 4'hE, 4'hF, 0, 0, 4'h0};
        tbl[8]  = '{0, 0, 0, 0, 0, 4'h0, 4'hE, 4'hF, 0, 0, 4'h0};
        tbl[9]  = '{0, 1, 1, 1, 3, 4'hF, 4'hC, 4'hF, 0, 1, 4'h0};
        tbl[10] = '{0, 0, 1, 0, 0, 4'h0, 4'hC, 4'hF, 0, 0, 4'h0};
        tbl[11] = '{0, 1, 1, 0, 0, 4'h0, 4'hC, 4'hF, 0, 1, 4'h4};
        tbl[12] = '{0, 1, 1, 0, 1, 4'h0, 4'hC, 4'hF, 0, 1, 4'hF};
        tbl[13] = '{0, 1, 1, 0, 2, 4'h0, 4'h4, 4'hF, 1, 1, 4'hC};
        tbl[14] = '{0, 1, 1, 0, 3, 4'h0, 4'h4, 4'hF, 1, 1, 4'h0};
        tbl[15] = '{0, 0, 0, 0, 0, 4'h0, 4'h4, 4'hF, 1, 0, 4'h0};
        tbl[16] = '{0, 0, 0, 0, 0, 4'h0, 4'h4, 4'hF, 1, 0, 4'h0};
        tbl[17] = '{0, 0, 0, 0, 0, 4'h0, 4'h4, 4'hF, 1, 0, 4'h0};
        tbl[18] = '{0, 1, 1, 1, 0, 4'h0, 4'h4, 4'hF, 1, 1, 4'h0};
        tbl[19] = '{0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF, 1, 0, 4'h0};
        tbl[20] = '{0, 1, 1, 0, 2, 4'h0, 4'h0, 4'hF, 1, 1, 4'h0};

        for (int r = 0; r < 21; r++) begin
            step(tbl[r].srst, tbl[r].cyc, tbl[r].stb, tbl[r].we, tbl[r].adr, tbl[r].dat);
            chk($sformatf("tbl%0d_rst", r),  8'(dom_rst_o),  8'(tbl[r].e_rst));
            chk($sformatf("tbl%0d_sync", r), 8'(dom_sync_o), 8'(tbl[r].e_sync));
            chk($sformatf("tbl%0d_done", r), 8'(por_done_o), 8'(tbl[r].e_done));
            chk($sformatf("tbl%0d_ack", r),  8'(ack_o),      8'(tbl[r].e_ack));
            chk($sformatf("tbl%0d_dat", r),  8'(dat_o),      8'(tbl[r].e_dat));
        end

        // Soft reset of domain 1, cleared one cycle after being set.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h2);
        chk("sr_e0", 8'(dom_rst_o[1]), 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0);
        chk("sr_e1", 8'(dom_rst_o[1]), 8'd1);
        chk("sr_e1_ack", 8'(ack_o), 8'd1);
        idle(1);
        chk("sr_e2", 8'(dom_rst_o[1]), 8'd1);
        idle(1);
        chk("sr_e3", 8'(dom_rst_o[1]), 8'd1);
        idle(1);
        chk("sr_e4", 8'(dom_rst_o[1]), 8'd0);

        // Clock gating of domain 0 and forced enable while in reset.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'hE);
        chk("cen_gate", 8'(dom_sync_o), 8'hE);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0);
        chk("cen_in_rst", 8'(dom_sync_o), 8'hF);
        idle(3);
        chk("cen_after_rel", 8'(dom_sync_o), 8'hE);

        // Ack squash: request accepted, then cyc_i dropped in the ack cycle.
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
        cyc_i = 1'b0; stb_i = 1'b0;
        #1;
        chk("ack_squash", 8'(ack_o), 8'd0);

        // Reset in RUN with domain 3 held and all clocks gated.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'h8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h0);
        idle(2);
        chk("pre_rst_sync", 8'(dom_sync_o), 8'h8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        chk("mid_rst_dom",  8'(dom_rst_o),  8'hF);
        chk("mid_rst_sync", 8'(dom_sync_o), 8'hF);
        chk("mid_rst_done", 8'(por_done_o), 8'd0);
        for (int e = 0; e <= LAST; e++) begin
            if (e == 1)      step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0);
            else if (e == 2) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
            else             idle(1);
            if (e == 1) chk("rst_reg_cleared", 8'(dat_o), 8'h0);
            if (e == 2) chk("cen_reg_restored", 8'(dat_o), 8'hF);
            if (e == 3) chk("rerun_e3", 8'(dom_rst_o), 8'hF);
            if (e == 4) chk("rerun_e4", 8'(dom_rst_o), 8'hE);
            if (e == LAST - 1) chk("rerun_pre_done", 8'(por_done_o), 8'd0);
        end
        chk("rerun_done", 8'(por_done_o), 8'd1);
        chk("rerun_dom",  8'(dom_rst_o),  8'h0);

        // Random traffic with occasional resets, checked against the model.
        for (int k = 0; k < 3000; k++) begin
            logic rs, c, s, w;
            rs = ($urandom_range(0, 299) == 0);
            c  = ($urandom_range(0, 9) < 8);
            s  = ($urandom_range(0, 9) < 7);
            w  = $urandom_range(0, 1) == 1;
            step(rs, c, s, w, 2'($urandom_range(0, 3)), N'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
